// File: rtl/cpc_sixrom_pkg.sv
// Shared types and constants for the six-ROM expansion board select logic.
package cpc_sixrom_pkg;

  // Capture FSM for the upper-ROM select write (port &DFxx)
  typedef enum logic [2:0] {
    StArm,
    StIdle,
    StQual,
    StCapt,
    StHold
  } cap_state_e;

  localparam int unsigned NUM_SLOTS   = 6;
  localparam int unsigned NUM_SOCKETS = 3;

  // Socket index encodings, one per 32K EEPROM
  localparam logic [1:0] SockRom01 = 2'd0;
  localparam logic [1:0] SockRom23 = 2'd1;
  localparam logic [1:0] SockRom45 = 2'd2;

endpackage

// File: rtl/cpc_sixrom_select_if.sv
// CPC edge-connector bus, DIP switches and EEPROM control lines of the six-ROM board.
interface cpc_sixrom_select_if;

  logic       IOREQ_B;
  logic       WR_B;
  logic       RD_B;
  logic       MREQ_B;
  logic       ROMEN_B;
  logic       A15;
  logic       A14;
  logic       A13;
  logic [7:0] D;
  logic [7:0] dip;

  logic       rom01cs_b;
  logic       rom23cs_b;
  logic       rom45cs_b;
  logic       romoe_b;
  logic       roma14;
  logic       romdis_pre;

  // Bus side: drives strobes, address, data and switches
  modport master (
    output IOREQ_B, WR_B, RD_B, MREQ_B, ROMEN_B, A15, A14, A13, D, dip,
    input  rom01cs_b, rom23cs_b, rom45cs_b, romoe_b, roma14, romdis_pre
  );

  // CPLD side: snoops the bus, drives the EEPROM controls
  modport slave (
    input  IOREQ_B, WR_B, RD_B, MREQ_B, ROMEN_B, A15, A14, A13, D, dip,
    output rom01cs_b, rom23cs_b, rom45cs_b, romoe_b, roma14, romdis_pre
  );

endinterface

// File: rtl/rom_slot_match.sv
// Maps a latched ROM number onto the DIP-configured six-slot window.
module rom_slot_match
  import cpc_sixrom_pkg::*;
(
  input  logic [7:0] rom_num,
  input  logic       valid,
  input  logic [7:0] dip,
  output logic       hit,
  output logic [1:0] sock,
  output logic       a14
);

  logic [3:0] idx;
  logic       sock_en;

  // Slot offset from base wraps in 4 bits; socket pairs consecutive slots
  always_comb begin
    idx     = rom_num[3:0] - dip[3:0];
    sock    = idx[2:1];
    a14     = idx[0];
    sock_en = 1'b0;
    case (sock)
      SockRom01: sock_en = dip[4];
      SockRom23: sock_en = dip[5];
      SockRom45: sock_en = dip[6];
      default:   sock_en = 1'b0;
    endcase
    hit = valid & dip[7] & (rom_num[7:4] == 4'd0) & (idx < 4'(NUM_SLOTS)) & sock_en;
  end

endmodule

// File: rtl/cpc_sixrom_select.sv
// Upper-ROM select snooper and EEPROM chip-select controller for the six-ROM board.
module cpc_sixrom_select
  import cpc_sixrom_pkg::*;
#(
  parameter int unsigned FILTER_SAMPLES = 2
) (
  input logic                 CLK,
  input logic                 RESET,
  cpc_sixrom_select_if.slave  bus
);

  logic       wstb;
  cap_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] rom_num_q, rom_num_d;
  logic       valid_q, valid_d;

  logic       match_hit;
  logic [1:0] match_sock;
  logic       match_a14;
  logic       sel_hit_q;
  logic [1:0] sel_sock_q;
  logic       sel_a14_q;

  logic                   acc;
  logic [NUM_SOCKETS-1:0] cs_b;

  assign wstb = ~bus.IOREQ_B & ~bus.WR_B & ~bus.A13;

  // Capture FSM next state: filter the write strobe, capture once per strobe
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rom_num_d = rom_num_q;
    valid_d   = valid_q;
    case (state_q)
      StArm: begin
        if (!wstb) state_d = StIdle;
      end
      StIdle: begin
        if (wstb) begin
          cnt_d   = 2'd1;
          state_d = (FILTER_SAMPLES == 1) ? StCapt : StQual;
        end
      end
      StQual: begin
        if (wstb) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_d == 2'(FILTER_SAMPLES)) state_d = StCapt;
        end else begin
          state_d = StIdle;
        end
      end
      StCapt: begin
        rom_num_d = bus.D;
        valid_d   = 1'b1;
        state_d   = StHold;
      end
      StHold: begin
        if (!wstb) state_d = StIdle;
      end
      default: state_d = StArm;
    endcase
  end

  // Capture FSM and latched ROM number
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StArm;
      cnt_q     <= 2'd0;
      rom_num_q <= 8'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rom_num_q <= rom_num_d;
      valid_q   <= valid_d;
    end
  end

  rom_slot_match u_match (
    .rom_num (rom_num_q),
    .valid   (valid_q),
    .dip     (bus.dip),
    .hit     (match_hit),
    .sock    (match_sock),
    .a14     (match_a14)
  );

  // Selection register refreshed every cycle so only registered terms change at an edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sel_hit_q  <= 1'b0;
      sel_sock_q <= SockRom01;
      sel_a14_q  <= 1'b0;
    end else begin
      sel_hit_q  <= match_hit;
      sel_sock_q <= match_sock;
      sel_a14_q  <= match_a14;
    end
  end

  // Gate the registered selection with live upper-ROM read strobes
  always_comb begin
    acc  = sel_hit_q & ~bus.ROMEN_B & ~bus.MREQ_B & bus.A15 & bus.A14;
    cs_b = '1;
    case (sel_sock_q)
      SockRom01: cs_b[0] = ~acc;
      SockRom23: cs_b[1] = ~acc;
      SockRom45: cs_b[2] = ~acc;
      default:   cs_b    = '1;
    endcase
    bus.rom01cs_b  = cs_b[0];
    bus.rom23cs_b  = cs_b[1];
    bus.rom45cs_b  = cs_b[2];
    bus.romoe_b    = ~(acc & ~bus.RD_B);
    bus.romdis_pre = acc;
    bus.roma14     = sel_a14_q;
  end

endmodule

// File: tb/tb_cpc_sixrom_select.sv
// Self-checking bench for cpc_sixrom_select: directed scenarios plus randomized writes/reads.
module tb_cpc_sixrom_select;

  localparam int unsigned FS = 2;

  logic CLK = 1'b0;
  logic RESET;
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference state: the ROM number the board should currently hold
  logic [7:0] m_rom;
  logic       m_valid;
  logic       m_in_reset;

  cpc_sixrom_select_if bus ();

  cpc_sixrom_select #(.FILTER_SAMPLES(FS)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.IOREQ_B = 1'b1;
    bus.WR_B    = 1'b1;
    bus.RD_B    = 1'b1;
    bus.MREQ_B  = 1'b1;
    bus.ROMEN_B = 1'b1;
    bus.A15     = 1'b1;
    bus.A14     = 1'b1;
    bus.A13     = 1'b1;
  endtask

  task automatic set_dip(input logic [7:0] v);
    @(negedge CLK);
    bus.dip = v;
    @(negedge CLK);
  endtask

  // I/O write to &DFxx: strobe low for len clocks; D switches to d_late after the capture edge
  task automatic io_write(input logic [7:0] d, input int len, input logic [7:0] d_late);
    @(negedge CLK);
    bus.D       = d;
    bus.IOREQ_B = 1'b0;
    bus.WR_B    = 1'b0;
    bus.A13     = 1'b0;
    for (int i = 1; i <= len + int'(FS); i++) begin
      @(negedge CLK);
      if (i == len) bus_idle();
      if (i == int'(FS) + 1) bus.D = d_late;
    end
    repeat (3) @(negedge CLK);
    if (len >= int'(FS)) begin
      m_rom   = d;
      m_valid = 1'b1;
    end
  endtask

  // Apply a memory-side bus state and compare every output against the reference
  task automatic check_read(input string tag, input logic romen_b, input logic mreq_b,
                            input logic rd_b, input logic a15, input logic a14);
    int   slot;
    logic hit, acc;
    @(negedge CLK);
    bus.IOREQ_B = 1'b1;
    bus.WR_B    = 1'b1;
    bus.ROMEN_B = romen_b;
    bus.MREQ_B  = mreq_b;
    bus.RD_B    = rd_b;
    bus.A15     = a15;
    bus.A14     = a14;
    #1;
    slot = ((int'(m_rom) % 16) - (int'(bus.dip) % 16) + 16) % 16;
    hit  = m_valid && bus.dip[7] && (m_rom < 8'd16) && (slot < 6) && bus.dip[4 + slot / 2];
    acc  = hit && !romen_b && !mreq_b && a15 && a14;
    chk({tag, "_cs01"}, bus.rom01cs_b, !(acc && slot / 2 == 0));
    chk({tag, "_cs23"}, bus.rom23cs_b, !(acc && slot / 2 == 1));
    chk({tag, "_cs45"}, bus.rom45cs_b, !(acc && slot / 2 == 2));
    chk({tag, "_oe"}, bus.romoe_b, !(acc && !rd_b));
    chk({tag, "_a14"}, bus.roma14, m_in_reset ? 1'b0 : 1'(slot % 2));
    chk({tag, "_romdis"}, bus.romdis_pre, acc);
    bus_idle();
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] v;

    RESET      = 1'b1;
    bus_idle();
    bus.D      = 8'h00;
    bus.dip    = 8'hF4;
    m_rom      = 8'h00;
    m_valid    = 1'b0;
    m_in_reset = 1'b1;
    repeat (2) @(negedge CLK);
    check_read("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge CLK);
    RESET      = 1'b0;
    m_in_reset = 1'b0;

    // B=4, all sockets on: ROM 5 -> slot 1 -> ROM01 upper half
    io_write(8'h05, 3, 8'h05);
    check_read("df05_rd", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_read("df05_nord", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_read("df05_romen_off", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // ROM 10 -> slot 6, outside window
    io_write(8'h0A, 3, 8'h0A);
    check_read("df0a_rd", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Wrap-around: B=14, ROM 1 -> slot 3 -> ROM23 upper half; then disable ROM23
    set_dip(8'hFE);
    io_write(8'h01, 3, 8'h01);
    check_read("wrap_rd", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    set_dip(8'hDE);
    check_read("wrap_dis", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // One-clock glitch must not capture; a long strobe captures once
    set_dip(8'hF4);
    io_write(8'h05, 3, 8'h05);
    io_write(8'h0A, 1, 8'h0A);
    check_read("glitch", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    io_write(8'h08, 10, 8'h0A);
    check_read("long_strobe", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a strobe with an upper read active
    io_write(8'h05, 3, 8'h05);
    @(negedge CLK);
    bus.D       = 8'h0A;
    bus.IOREQ_B = 1'b0;
    bus.WR_B    = 1'b0;
    bus.A13     = 1'b0;
    bus.MREQ_B  = 1'b0;
    bus.ROMEN_B = 1'b0;
    bus.RD_B    = 1'b0;
    bus.A15     = 1'b1;
    bus.A14     = 1'b1;
    RESET       = 1'b1;
    #1;
    chk("rst_pre_cs01", bus.rom01cs_b, 1'b0);
    chk("rst_pre_romdis", bus.romdis_pre, 1'b1);
    @(negedge CLK);
    #1;
    chk("rst_edge_cs01", bus.rom01cs_b, 1'b1);
    chk("rst_edge_cs23", bus.rom23cs_b, 1'b1);
    chk("rst_edge_cs45", bus.rom45cs_b, 1'b1);
    chk("rst_edge_oe", bus.romoe_b, 1'b1);
    chk("rst_edge_a14", bus.roma14, 1'b0);
    chk("rst_edge_romdis", bus.romdis_pre, 1'b0);
    RESET   = 1'b0;
    bus.D   = 8'h05;
    m_rom   = 8'h00;
    m_valid = 1'b0;
    repeat (6) @(negedge CLK);
    bus_idle();
    repeat (3) @(negedge CLK);
    check_read("rst_nocap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    io_write(8'h05, 3, 8'h05);
    check_read("rst_recap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Lower-ROM access never selects; upper nibble set never hits
    check_read("lower_rd", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    io_write(8'h15, 3, 8'h15);
    check_read("df15_rd", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Randomized configuration, writes and bus states
    for (int n = 0; n < 40; n++) begin
      v = {1'($urandom_range(0, 7) != 0), 3'($urandom), 4'($urandom)};
      set_dip(v);
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
      io_write(d, int'($urandom_range(1, 4)), 8'($urandom));
      check_read("rnd_upper", 1'b0, 1'b0, 1'($urandom), 1'b1, 1'b1);
      check_read("rnd_bus", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
